bitstream_writer: RTL and testbench
===================================

# bitstream_writer

Serialises a parameter-width parallel word onto a 1-bit AXI-stream, one bit per beat, marking the final bit with `tlast`. It is the transmit-side counterpart of the bitstream reader. Typical uses:
- driving configuration bits into the fabric's bitstream port;
- returning captured state (readback) to an external host.

A single `start` pulse launches one transfer; `done` pulses when the last beat has been accepted.

## Interface
Parameters:
- `NUM_BITS_TO_WRITE`, default 8: number of bits per transfer; legal range ≥ 1.
- `LSB_FIRST`, default 1: bit order on the stream.
  - 1: `bits[0]` is sent first.
  - 0: `bits[NUM_BITS_TO_WRITE-1]` is sent first.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request to begin a transfer; honoured only in IDLE.
- `bits`  in  NUM_BITS_TO_WRITE  word to send; sampled on the cycle `start` is honoured.
- `bitstream`  axi_stream_if.master  master side of the stream:
  - `tvalid`, `tdata` and `tlast` are driven by this block;
  - `tready` is consumed by this block.
- `busy`  out  1  high while in SEND or DONE.
- `done`  out  1  single-cycle pulse after the final beat is accepted.

## Operation
- States:
  - IDLE → SEND when `start`=1; otherwise remain in IDLE.
  - SEND → DONE when the final beat is accepted; otherwise remain in SEND.
  - DONE → IDLE unconditionally.
  - Any illegal encoding → IDLE.
- On IDLE & `start`:
  - `bits` is copied into an internal shift register;
  - the beat counter is cleared to 0.
- In SEND:
  - `tvalid`=1.
  - `tdata` is the current head bit of the shift register (LSB or MSB according to `LSB_FIRST`).
  - `tlast` = (counter == NUM_BITS_TO_WRITE-1).
- Beat acceptance (`tvalid` & `tready`):
  - the shift register advances by one;
  - the counter increments.
- No acceptance: the shift register, counter, `tdata` and `tlast` all hold.
- Counter width is max(1, $clog2(NUM_BITS_TO_WRITE)). The counter never exceeds NUM_BITS_TO_WRITE-1, so it does not wrap.
- `start` in SEND or DONE is ignored, not queued. Changes on `bits` after capture have no effect on the transfer in progress.
- `done` = (state == DONE).
- `busy` = (state != IDLE).
- Reset values: state IDLE, `tvalid`=0, `tdata`=0, `tlast`=0, `busy`=0, `done`=0, counter 0, shift register 0.
- When not in SEND, `tdata` and `tlast` are driven 0.

## Timing
- `start` high at edge N (in IDLE):
  - first beat is presented (`tvalid`=1) from cycle N+1;
  - there is no combinational path from `start` to `tvalid`.
- With `tready` held at 1:
  - beat k (k = 0 … NUM_BITS_TO_WRITE-1) is presented in cycle N+1+k;
  - `done` is high in cycle N+1+NUM_BITS_TO_WRITE;
  - IDLE is re-entered in cycle N+2+NUM_BITS_TO_WRITE.
- Minimum start-to-start spacing is NUM_BITS_TO_WRITE+2 cycles. `start` is honoured again in the first IDLE cycle after DONE.
- AXI rules:
  - once `tvalid` rises, it stays high, with `tdata`/`tlast` stable, until the beat is accepted;
  - `tvalid` never depends combinationally on `tready`.
- NUM_BITS_TO_WRITE = 1: `tlast`=1 on the only beat.
- `rst_n`=0 mid-transfer: at the next edge, state goes to IDLE and `tvalid` drops. The partial transfer is abandoned with no `tlast` and no `done`. This is the sole permitted exception to `tvalid` stickiness.

## Structure
- Package `bitstream_pkg`:
  - the writer state enum `t_bitstream_writer_state` (IDLE, SEND, DONE);
  - a shared bit-order constant type.
  - The reader may later adopt the same package.
- No sub-module is needed. The shift register, counter and FSM stay in a single module of roughly 150 lines.

## Test plan
- NUM_BITS_TO_WRITE=8, `LSB_FIRST`=1, `bits`=8'hA5, `tready`=1:
  - `tdata` sequence 1,0,1,0,0,1,0,1 in cycles N+1…N+8;
  - `tlast` only at N+8;
  - `done` at N+9;
  - `busy` high N+1…N+9.
- Same word, `LSB_FIRST`=0: `tdata` sequence 1,0,1,0,0,1,0,1 (palindrome), then repeat with 8'h0F → 0,0,0,0,1,1,1,1.
- Backpressure, `tready` toggling 1,0,0,1,…:
  - `tdata`/`tlast` are held stable while `tvalid` & !`tready`;
  - exactly 8 beats are accepted;
  - `done` comes one cycle after the last accepted beat.
- `start` pulsed in SEND and in DONE:
  - both are ignored; `bits` is changed to 8'hFF mid-transfer and the stream is still 8'hA5;
  - a `start` on the first IDLE cycle launches a new transfer.
- NUM_BITS_TO_WRITE=1, `bits`=1: a single beat with `tdata`=1 and `tlast`=1, then `done` the next cycle.
- `rst_n`=0 asserted after 3 accepted beats:
  - at the next edge `tvalid`=0, `busy`=0, and `done` never pulses;
  - a fresh `start` then sends all 8 bits from bit 0.

Source files
------------

// File: rtl/bitstream_pkg.sv
// Shared types for the bitstream writer (and, later, the reader).
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } t_bitstream_writer_state;

    typedef enum logic {
        BIT_ORDER_MSB_FIRST = 1'b0,
        BIT_ORDER_LSB_FIRST = 1'b1
    } t_bit_order;

endpackage

// File: rtl/axi_stream_if.sv
// 1-bit AXI-stream channel: master drives valid/data/last, slave drives ready.
interface axi_stream_if;

    logic tvalid;
    logic tready;
    logic tdata;
    logic tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/bitstream_writer.sv
// Serialises a parallel word onto a 1-bit AXI-stream, one bit per beat,
// flagging the final bit with tlast and pulsing done once it is accepted.
//
// state | meaning
// IDLE  | waiting for start; stream outputs low
// SEND  | presenting beats until the last one is accepted
// DONE  | one-cycle completion pulse, start ignored
module bitstream_writer
    import bitstream_pkg::*;
#(
    parameter int NUM_BITS_TO_WRITE = 8,
    parameter bit LSB_FIRST         = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_BITS_TO_WRITE-1:0] bits,
    axi_stream_if.master                 bitstream,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = (NUM_BITS_TO_WRITE > 1) ? $clog2(NUM_BITS_TO_WRITE) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BITS_TO_WRITE - 1);
    localparam t_bit_order ORDER = LSB_FIRST ? BIT_ORDER_LSB_FIRST : BIT_ORDER_MSB_FIRST;

    t_bitstream_writer_state      r_state;
    logic [NUM_BITS_TO_WRITE-1:0] r_shift;
    logic [CW-1:0]                r_cnt;
    logic                         r_tvalid;
    logic                         r_tdata;
    logic                         r_tlast;
    logic                         r_busy;
    logic                         r_done;

    logic [NUM_BITS_TO_WRITE-1:0] w_shift_next;
    logic [CW-1:0]                w_cnt_next;
    logic                         w_accept;

    function automatic logic head_bit(input logic [NUM_BITS_TO_WRITE-1:0] v);
        return (ORDER == BIT_ORDER_LSB_FIRST) ? v[0] : v[NUM_BITS_TO_WRITE-1];
    endfunction

    always_comb begin
        w_accept   = r_tvalid & bitstream.tready;
        w_cnt_next = r_cnt + CW'(1);
        if (ORDER == BIT_ORDER_LSB_FIRST)
            w_shift_next = r_shift >> 1;
        else
            w_shift_next = r_shift << 1;
    end

    // tdata/tlast are registered one step ahead so they always reflect the
    // head of the shift register and the counter without a combinational path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SEND;
                        r_shift  <= bits;
                        r_cnt    <= '0;
                        r_tvalid <= 1'b1;
                        r_tdata  <= head_bit(bits);
                        r_tlast  <= (LAST_BEAT == '0);
                        r_busy   <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_shift <= w_shift_next;
                        if (r_tlast) begin
                            r_state  <= DONE;
                            r_tvalid <= 1'b0;
                            r_tdata  <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_tdata <= head_bit(w_shift_next);
                            r_tlast <= (w_cnt_next == LAST_BEAT);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_tvalid <= 1'b0;
                    r_tdata  <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign bitstream.tvalid = r_tvalid;
    assign bitstream.tdata  = r_tdata;
    assign bitstream.tlast  = r_tlast;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_bitstream_writer.sv
// Directed bench: 8-bit LSB-first, 8-bit MSB-first and 1-bit writers.
module tb_bitstream_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic [2:0] tready_v = '1;
    logic [7:0] bits_l = '0;
    logic [7:0] bits_m = '0;
    logic [0:0] bits_1 = '0;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic       tv [3];
    logic       td [3];
    logic       tl [3];

    int checks = 0;
    int errors = 0;

    axi_stream_if if_l ();
    axi_stream_if if_m ();
    axi_stream_if if_1 ();

    assign if_l.tready = tready_v[0];
    assign if_m.tready = tready_v[1];
    assign if_1.tready = tready_v[2];
    assign tv[0] = if_l.tvalid;  assign td[0] = if_l.tdata;  assign tl[0] = if_l.tlast;
    assign tv[1] = if_m.tvalid;  assign td[1] = if_m.tdata;  assign tl[1] = if_m.tlast;
    assign tv[2] = if_1.tvalid;  assign td[2] = if_1.tdata;  assign tl[2] = if_1.tlast;

    bitstream_writer #(.NUM_BITS_TO_WRITE(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bits(bits_l),
        .bitstream(if_l), .busy(busy_v[0]), .done(done_v[0]));

    bitstream_writer #(.NUM_BITS_TO_WRITE(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bits(bits_m),
        .bitstream(if_m), .busy(busy_v[1]), .done(done_v[1]));

    bitstream_writer #(.NUM_BITS_TO_WRITE(1), .LSB_FIRST(1'b1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bits(bits_1),
        .bitstream(if_1), .busy(busy_v[2]), .done(done_v[2]));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called with the first beat presented; seq[k] is the expected k-th beat.
    task automatic run_beats(input int d, input logic [7:0] seq, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("d%0d_beat%0d_tvalid", d, k), tv[d], 1'b1);
            chk($sformatf("d%0d_beat%0d_tdata", d, k), td[d], seq[k]);
            chk($sformatf("d%0d_beat%0d_tlast", d, k), tl[d], (k == n - 1));
            chk($sformatf("d%0d_beat%0d_busy", d, k), busy_v[d], 1'b1);
            chk($sformatf("d%0d_beat%0d_done", d, k), done_v[d], 1'b0);
            tick();
        end
        chk($sformatf("d%0d_done_pulse", d), done_v[d], 1'b1);
        chk($sformatf("d%0d_done_busy", d), busy_v[d], 1'b1);
        chk($sformatf("d%0d_done_tvalid", d), tv[d], 1'b0);
        chk($sformatf("d%0d_done_tlast", d), tl[d], 1'b0);
        tick();
        chk($sformatf("d%0d_idle_done", d), done_v[d], 1'b0);
        chk($sformatf("d%0d_idle_busy", d), busy_v[d], 1'b0);
    endtask

    initial begin
        int acc;
        int cyc;
        logic tr;

        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_tvalid_d%0d", d), tv[d], 1'b0);
            chk($sformatf("rst_tdata_d%0d", d), td[d], 1'b0);
            chk($sformatf("rst_tlast_d%0d", d), tl[d], 1'b0);
            chk($sformatf("rst_busy_d%0d", d), busy_v[d], 1'b0);
            chk($sformatf("rst_done_d%0d", d), done_v[d], 1'b0);
        end
        rst_n = 1'b1;
        tick();

        // LSB-first 8'hA5
        bits_l = 8'hA5;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        run_beats(0, 8'hA5, 8);

        // MSB-first 8'hA5 (palindrome) and 8'h0F -> 0,0,0,0,1,1,1,1
        bits_m = 8'hA5;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        run_beats(1, 8'hA5, 8);
        bits_m = 8'h0F;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        run_beats(1, 8'hF0, 8);

        // Backpressure with tready pattern 1,0,0,1 repeating
        bits_l = 8'hA5;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 40) begin
            tr = (cyc % 4 == 0) || (cyc % 4 == 3);
            tready_v[0] = tr;
            chk($sformatf("bp_c%0d_tvalid", cyc), tv[0], 1'b1);
            chk($sformatf("bp_c%0d_tdata", cyc), td[0], 8'hA5 >> acc & 8'h01 ? 1'b1 : 1'b0);
            chk($sformatf("bp_c%0d_tlast", cyc), tl[0], (acc == 7));
            chk($sformatf("bp_c%0d_done", cyc), done_v[0], 1'b0);
            if (tr) acc++;
            cyc++;
            tick();
        end
        chk("bp_beats_accepted", (acc == 8), 1'b1);
        chk("bp_done", done_v[0], 1'b1);
        chk("bp_done_tvalid", tv[0], 1'b0);
        tready_v[0] = 1'b1;
        tick();
        chk("bp_idle_done", done_v[0], 1'b0);
        chk("bp_idle_busy", busy_v[0], 1'b0);

        // start in SEND (with bits changed) and in DONE is ignored
        bits_l = 8'hA5;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ign_beat%0d_tdata", k), td[0], (k == 0 || k == 2 || k == 5 || k == 7));
            chk($sformatf("ign_beat%0d_tlast", k), tl[0], (k == 7));
            if (k == 2) begin
                start_v[0] = 1'b1;
                bits_l = 8'hFF;
            end else begin
                start_v[0] = 1'b0;
            end
            tick();
        end
        chk("ign_done", done_v[0], 1'b1);
        start_v[0] = 1'b1;
        tick();
        chk("ign_done_start_busy", busy_v[0], 1'b0);
        chk("ign_done_start_tvalid", tv[0], 1'b0);
        bits_l = 8'h3C;
        tick();
        start_v[0] = 1'b0;
        run_beats(0, 8'h3C, 8);

        // Single-bit writer
        bits_1 = 1'b1;
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        run_beats(2, 8'h01, 1);

        // Reset after three accepted beats
        bits_l = 8'hA5;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_mid_tdata_beat3", td[0], 1'b0);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_tvalid", tv[0], 1'b0);
        chk("rst_mid_busy", busy_v[0], 1'b0);
        chk("rst_mid_done", done_v[0], 1'b0);
        chk("rst_mid_tlast", tl[0], 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_after_done", done_v[0], 1'b0);
        chk("rst_after_tvalid", tv[0], 1'b0);
        tick();
        chk("rst_after2_done", done_v[0], 1'b0);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        run_beats(0, 8'hA5, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
